// File: rtl/regfile_zero_param.sv
// regfile_zero_param: WIDTH x 2**ADDR_BITS register file with one synchronous
// write port and two combinational read ports. Entry ZERO_IDX always reads 0
// and ignores writes.
// Optional feature: define REGFILE_BYPASS_EN to forward the write-port data
// to a read port addressing the entry being written in the same cycle.
module regfile_zero_param #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ADDR_BITS = 5,
   parameter int unsigned ZERO_IDX  = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wrenable,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic [ADDR_BITS-1:0] rd_addr0,
   output logic [WIDTH-1:0]     rd_data0,
   input  logic [ADDR_BITS-1:0] rd_addr1,
   output logic [WIDTH-1:0]     rd_data1
);

   localparam int unsigned           DEPTH     = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS-1:0]  ZERO_ADDR = ADDR_BITS'(ZERO_IDX);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             wr_hit;
   logic [WIDTH-1:0] rd0_stored;
   logic [WIDTH-1:0] rd1_stored;

   // Qualified write: strobe high and target is a real storage entry.
   // The strobe is tested first so unknown address bits with the strobe low
   // cannot reach any entry.
   always_comb begin
      wr_hit = 1'b0;
      if (wrenable) begin
         wr_hit = (wr_addr != ZERO_ADDR);
      end
   end

   // Next-state of every entry; the zero entry is pinned to 0.
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (i == ZERO_IDX) begin
            mem_d[i] = '0;
         end else if (wr_hit && (wr_addr == ADDR_BITS'(i))) begin
            mem_d[i] = wr_data;
         end else begin
            mem_d[i] = mem_q[i];
         end
      end
   end

   // Storage update with synchronous active-low clear (reset beats write).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Stored read values; the zero entry is masked at the port, not trusted
   // from storage.
   always_comb begin
      rd0_stored = (rd_addr0 == ZERO_ADDR) ? '0 : mem_q[rd_addr0];
      rd1_stored = (rd_addr1 == ZERO_ADDR) ? '0 : mem_q[rd_addr1];
   end

`ifdef REGFILE_BYPASS_EN
   // Read ports with same-cycle write forwarding; wr_hit already excludes
   // the zero entry, and forwarding is blocked while reset is asserted.
   always_comb begin
      rd_data0 = rd0_stored;
      rd_data1 = rd1_stored;
      if (rst_n && wr_hit && (wr_addr == rd_addr0)) begin
         rd_data0 = wr_data;
      end
      if (rst_n && wr_hit && (wr_addr == rd_addr1)) begin
         rd_data1 = wr_data;
      end
   end
`else
   // Read ports reflect stored state only; a same-cycle write shows next cycle.
   always_comb begin
      rd_data0 = rd0_stored;
      rd_data1 = rd1_stored;
   end
`endif

endmodule

// File: tb/tb_regfile_zero_param.sv
// Testbench for regfile_zero_param. Two instances are built: the default
// configuration (32-bit, 32 entries, zero at 0) and a narrow one (16-bit,
// 8 entries, zero at 7). The same scenario list runs against each in turn.
// Honors REGFILE_BYPASS_EN for same-cycle read expectations.
module tb_regfile_zero_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wrenable;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  rd_addr0;
   logic [4:0]  rd_addr1;
   logic [31:0] rd0_a, rd1_a;
   logic [15:0] rd0_b, rd1_b;
   logic        we_a, we_b;
   int          sel;

   int n_checks;
   int n_fail;

   // Reference model state for the configuration under test
   logic [31:0] model [32];
   int unsigned depth;
   int unsigned zidx;
   logic [31:0] dmask;

   always #5 clk = ~clk;

   assign we_a = wrenable && (sel == 0);
   assign we_b = wrenable && (sel == 1);

   regfile_zero_param #(.WIDTH(32), .ADDR_BITS(5), .ZERO_IDX(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .wrenable(we_a),
      .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr0(rd_addr0), .rd_data0(rd0_a),
      .rd_addr1(rd_addr1), .rd_data1(rd1_a)
   );

   regfile_zero_param #(.WIDTH(16), .ADDR_BITS(3), .ZERO_IDX(7)) dut_b (
      .clk(clk), .rst_n(rst_n), .wrenable(we_b),
      .wr_addr(wr_addr[2:0]), .wr_data(wr_data[15:0]),
      .rd_addr0(rd_addr0[2:0]), .rd_data0(rd0_b),
      .rd_addr1(rd_addr1[2:0]), .rd_data1(rd1_b)
   );

   function automatic logic [31:0] obs0();
      return (sel == 1) ? {16'h0, rd0_b} : rd0_a;
   endfunction

   function automatic logic [31:0] obs1();
      return (sel == 1) ? {16'h0, rd1_b} : rd1_a;
   endfunction

   // Expected read value from the architectural rules
   function automatic logic [31:0] ref_rd(input logic [4:0] a);
      if (a == zidx) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (rst_n && wrenable && (wr_addr == a)) return wr_data & dmask;
`endif
      return model[a];
   endfunction

   function automatic logic [4:0] rnd_addr();
      return 5'($urandom_range(depth - 1));
   endfunction

   task automatic set_cfg(input int s);
      sel = s;
      if (s == 0) begin
         depth = 32; zidx = 0; dmask = 32'hFFFF_FFFF;
      end else begin
         depth = 8; zidx = 7; dmask = 32'h0000_FFFF;
      end
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   // One clock edge; the model applies the rules as of that edge
   task automatic step();
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (wrenable && (wr_addr != zidx)) begin
         model[wr_addr] = wr_data & dmask;
      end
      #1;
   endtask

   task automatic test_reset(input bit pre_check);
      rst_n = 1'b0; wrenable = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
      rd_addr0 = 5'd3; rd_addr1 = 5'd3;
      #1;
      if (pre_check) begin
         n_checks++;
         if (obs0() !== model[3]) begin
            n_fail++;
            $display("FAIL reset_no_bypass cfg%0d: got %h expected %h", sel, obs0(), model[3]);
         end
      end
      step();
      rst_n = 1'b1; wrenable = 1'b0;
      for (int a = 0; a < int'(depth); a++) begin
         rd_addr0 = 5'(a); rd_addr1 = 5'(int'(depth) - 1 - a);
         #1;
         n_checks++;
         if (obs0() !== 32'h0 || obs1() !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_clear cfg%0d addr %0d: got %h/%h expected 0", sel, a, obs0(), obs1());
         end
      end
   endtask

   task automatic test_write_read();
      wrenable = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678;
      step();
      wrenable = 1'b0; rd_addr0 = 5'd5; rd_addr1 = 5'd6;
      #1;
      n_checks++;
      if (obs0() !== (32'h12345678 & dmask)) begin
         n_fail++;
         $display("FAIL write_read cfg%0d port0: got %h expected %h", sel, obs0(), 32'h12345678 & dmask);
      end
      n_checks++;
      if (obs1() !== 32'h0) begin
         n_fail++;
         $display("FAIL write_read cfg%0d port1: got %h expected 0", sel, obs1());
      end
   endtask

   task automatic test_zero_write();
      wrenable = 1'b1; wr_addr = 5'(zidx); wr_data = 32'hFFFFFFFF;
      rd_addr0 = 5'(zidx); rd_addr1 = 5'(zidx);
      #1;
      n_checks++;
      if (obs0() !== 32'h0 || obs1() !== 32'h0) begin
         n_fail++;
         $display("FAIL zero_write_pre cfg%0d: got %h/%h expected 0", sel, obs0(), obs1());
      end
      step();
      for (int i = 0; i < 10; i++) begin
         wrenable = 1'b1;
         wr_addr = (i % 2 == 0) ? 5'(zidx) : rnd_addr();
         wr_data = $urandom;
         #1;
         n_checks++;
         if (obs0() !== 32'h0 || obs1() !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_write cfg%0d iter %0d: got %h/%h expected 0", sel, i, obs0(), obs1());
         end
         step();
      end
      wrenable = 1'b0;
   endtask

   task automatic test_hold();
      logic [4:0] top;
      top = 5'(depth - 1);
      wrenable = 1'b1; wr_addr = top; wr_data = 32'hA5A5A5A5;
      step();
      for (int i = 0; i < 20; i++) begin
         wrenable = 1'b0; wr_addr = rnd_addr(); wr_data = $urandom;
         rd_addr0 = top; rd_addr1 = rnd_addr();
         #1;
         n_checks++;
         if (obs0() !== ref_rd(top) || obs1() !== ref_rd(rd_addr1)) begin
            n_fail++;
            $display("FAIL hold cfg%0d iter %0d: got %h/%h expected %h/%h",
                     sel, i, obs0(), obs1(), ref_rd(top), ref_rd(rd_addr1));
         end
         step();
      end
      for (int a = 0; a < int'(depth); a++) begin
         rd_addr0 = 5'(a); rd_addr1 = 5'(a);
         #1;
         n_checks++;
         if (obs0() !== ref_rd(5'(a)) || obs1() !== obs0()) begin
            n_fail++;
            $display("FAIL hold_sweep cfg%0d addr %0d: got %h/%h expected %h",
                     sel, a, obs0(), obs1(), ref_rd(5'(a)));
         end
      end
   endtask

   task automatic test_rdw();
      logic [4:0]  a;
      logic [31:0] exp_pre;
      a = (zidx == 7) ? 5'd6 : 5'd7;
      wrenable = 1'b1; wr_addr = a; wr_data = 32'h1;
      step();
      wr_data = 32'h2; rd_addr0 = a; rd_addr1 = a;
      #1;
`ifdef REGFILE_BYPASS_EN
      exp_pre = 32'h2;
`else
      exp_pre = 32'h1;
`endif
      n_checks++;
      if (obs0() !== exp_pre || obs1() !== exp_pre) begin
         n_fail++;
         $display("FAIL rdw_before cfg%0d: got %h/%h expected %h", sel, obs0(), obs1(), exp_pre);
      end
      step();
      wrenable = 1'b0;
      #1;
      n_checks++;
      if (obs0() !== 32'h2) begin
         n_fail++;
         $display("FAIL rdw_after cfg%0d: got %h expected 2", sel, obs0());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         wrenable = ($urandom_range(2) != 0);
         wr_addr  = rnd_addr();
         wr_data  = $urandom;
         rd_addr0 = ($urandom_range(2) == 0) ? wr_addr : rnd_addr();
         rd_addr1 = ($urandom_range(3) == 0) ? rd_addr0 : rnd_addr();
         #1;
         n_checks++;
         if (obs0() !== ref_rd(rd_addr0) || obs1() !== ref_rd(rd_addr1)) begin
            n_fail++;
            $display("FAIL random cfg%0d iter %0d: got %h/%h expected %h/%h",
                     sel, i, obs0(), obs1(), ref_rd(rd_addr0), ref_rd(rd_addr1));
         end
         step();
      end
      wrenable = 1'b0;
   endtask

   task automatic run_cfg(input int s, input bit pre_check);
      set_cfg(s);
      test_reset(pre_check);
      test_write_read();
      test_zero_write();
      test_hold();
      test_rdw();
      test_random();
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      sel = 0;
      rst_n = 1'b1; wrenable = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr0 = '0; rd_addr1 = '0;
      @(negedge clk);
      run_cfg(0, 1'b0);
      run_cfg(1, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
